// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/MEM round-robin arbiter for the single external memory port with bus timeout
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          mem_req,
   input  logic          mem_we,
   input  logic [3:0]    mem_be,
   input  logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_wdata,
   output logic          mem_ack,
   output logic [DW-1:0] mem_rdata,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          bus_req,
   output logic          bus_we,
   output logic [3:0]    bus_be,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic          bus_ack,
   input  logic [DW-1:0] bus_rdata,
   output logic          bus_err
);

   typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, DONE} state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          last_mem_q, last_mem_d;
   logic          bus_req_q, bus_req_d;
   logic          bus_we_q, bus_we_d;
   logic [3:0]    bus_be_q, bus_be_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          if_ack_q, if_ack_d;
   logic          mem_ack_q, mem_ack_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] mem_rdata_q, mem_rdata_d;
   logic          bus_err_q, bus_err_d;
   logic          grant_mem;
   logic [DW-1:0] rd_data;

   always_comb begin
      state_d     = state_q;
      last_mem_d  = last_mem_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_be_d    = bus_be_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      cnt_d       = cnt_q;
      if_ack_d    = 1'b0;
      mem_ack_d   = 1'b0;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      bus_err_d   = bus_err_q;
      grant_mem   = 1'b0;
      rd_data     = '0;

      case (state_q)
         IDLE: begin
            if (if_req || mem_req) begin
               // MEM wins contention unless it was the last one served
               grant_mem = mem_req && (!if_req || !last_mem_q);
               bus_req_d = 1'b1;
               cnt_d     = '0;
               if (grant_mem) begin
                  state_d     = BUS_MEM;
                  bus_we_d    = mem_we;
                  bus_be_d    = mem_be;
                  bus_addr_d  = mem_addr;
                  bus_wdata_d = mem_wdata;
               end else begin
                  state_d     = BUS_IF;
                  bus_we_d    = 1'b0;
                  bus_be_d    = 4'hF;
                  bus_addr_d  = if_addr;
                  bus_wdata_d = '0;
               end
            end
         end
         BUS_IF, BUS_MEM: begin
            // an ack in the final timeout cycle still counts as success
            if (bus_ack || cnt_q == CNT_LAST) begin
               state_d    = DONE;
               bus_req_d  = 1'b0;
               last_mem_d = (state_q == BUS_MEM);
               rd_data    = (bus_ack && !bus_we_q) ? bus_rdata : '0;
               if (!bus_ack) begin
                  bus_err_d = 1'b1;
               end
               if (state_q == BUS_MEM) begin
                  mem_ack_d   = 1'b1;
                  mem_rdata_d = rd_data;
               end else begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = rd_data;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         last_mem_q  <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_be_q    <= '0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         cnt_q       <= '0;
         if_ack_q    <= 1'b0;
         mem_ack_q   <= 1'b0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_mem_q  <= last_mem_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_be_q    <= bus_be_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         cnt_q       <= cnt_d;
         if_ack_q    <= if_ack_d;
         mem_ack_q   <= mem_ack_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign if_ack    = if_ack_q;
   assign if_rdata  = if_rdata_q;
   assign mem_ack   = mem_ack_q;
   assign mem_rdata = mem_rdata_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_be    = bus_be_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_err   = bus_err_q;
   assign stall_if  = if_req & ~if_ack_q;
   assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed plus randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [DW-1:0] if_rdata;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [3:0]    mem_be = '0;
   logic [AW-1:0] mem_addr = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          stall_if, stall_mem;
   logic          bus_req, bus_we;
   logic [3:0]    bus_be;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_ack = 1'b0;
   logic [DW-1:0] bus_rdata = '0;
   logic          bus_err;

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // model state: who was served last, sticky error, last delivered read data
   bit            last_mem;
   bit            err_exp;
   logic [DW-1:0] if_rd_exp, mem_rd_exp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      last_mem   = 1'b0;
      err_exp    = 1'b0;
      if_rd_exp  = '0;
      mem_rd_exp = '0;
   endtask

   // Called at a negedge with the DUT idle and requests already driven; lat == TO means no bus_ack.
   task automatic serve(input int lat);
      bit            w_mem, timed_out;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd, rd;
      logic          ewe;
      logic [3:0]    ebe;
      #1;
      chk("stall_if_req", 64'(stall_if), 64'(if_req));
      chk("stall_mem_req", 64'(stall_mem), 64'(mem_req));
      w_mem = mem_req && (!if_req || !last_mem);
      if (w_mem) begin
         ea = mem_addr; ewe = mem_we; ebe = mem_be; ewd = mem_wdata;
      end else begin
         ea = if_addr; ewe = 1'b0; ebe = 4'hF; ewd = '0;
      end
      tick();
      bus_ack = 1'b0;
      chk("bus_req_on", 64'(bus_req), 64'd1);
      chk("bus_addr", 64'(bus_addr), 64'(ea));
      chk("bus_we", 64'(bus_we), 64'(ewe));
      chk("bus_be", 64'(bus_be), 64'(ebe));
      chk("bus_wdata", 64'(bus_wdata), 64'(ewd));
      if_addr   = $urandom;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      mem_we    = 1'($urandom_range(0, 1));
      mem_be    = 4'($urandom_range(0, 15));
      rd        = $urandom;
      timed_out = 1'b1;
      for (int k = 0; k < TO; k++) begin
         if (k == lat) begin
            bus_ack = 1'b1;
            bus_rdata = rd;
         end
         tick();
         bus_ack   = 1'b0;
         bus_rdata = $urandom;
         if (k == lat) begin
            timed_out = 1'b0;
            break;
         end
         if (k == TO - 1) break;
         chk("bus_req_hold", 64'(bus_req), 64'd1);
         chk("bus_addr_hold", 64'(bus_addr), 64'(ea));
      end
      if (w_mem) mem_rd_exp = (timed_out || ewe) ? '0 : rd;
      else       if_rd_exp  = timed_out ? '0 : rd;
      if (timed_out) err_exp = 1'b1;
      chk("bus_req_off", 64'(bus_req), 64'd0);
      chk("if_ack", 64'(if_ack), 64'(!w_mem));
      chk("mem_ack", 64'(mem_ack), 64'(w_mem));
      chk("if_rdata", 64'(if_rdata), 64'(if_rd_exp));
      chk("mem_rdata", 64'(mem_rdata), 64'(mem_rd_exp));
      chk("bus_err", 64'(bus_err), 64'(err_exp));
      chk("stall_if_ack", 64'(stall_if), 64'(if_req && w_mem));
      chk("stall_mem_ack", 64'(stall_mem), 64'(mem_req && !w_mem));
      last_mem = w_mem;
      if (w_mem) mem_req = 1'b0;
      else       if_req  = 1'b0;
      tick();
      chk("ack_single_pulse", 64'({if_ack, mem_ack}), 64'd0);
      chk("bus_req_gap", 64'(bus_req), 64'd0);
      chk("if_rdata_hold", 64'(if_rdata), 64'(if_rd_exp));
      chk("mem_rdata_hold", 64'(mem_rdata), 64'(mem_rd_exp));
   endtask

   initial begin
      model_reset();
      tick();
      tick();
      chk("rst_bus_req", 64'(bus_req), 64'd0);
      chk("rst_acks", 64'({if_ack, mem_ack}), 64'd0);
      chk("rst_bus_err", 64'(bus_err), 64'd0);
      chk("rst_bus_fields", 64'({bus_we, bus_be, bus_addr}), 64'd0);
      chk("rst_rdata", 64'({if_rdata, mem_rdata}), 64'd0);
      rstn = 1'b1;
      tick();

      // contention right after reset: MEM, then IF, then alternation continues
      if_req = 1'b1; if_addr = 32'h100;
      mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h400;
      chk("first_winner_mem", 64'(mem_req && (!if_req || !last_mem)), 64'd1);
      serve(0);
      serve(1);
      if_req = 1'b1; mem_req = 1'b1;
      serve(2);
      serve(0);

      // single fetch with immediate ack
      if_req = 1'b1; if_addr = 32'h100;
      serve(0);

      // store with a delayed ack
      mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h200; mem_wdata = 32'h1234;
      serve(2);

      // bus_ack while idle must be ignored
      bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
      tick();
      bus_ack = 1'b0;
      chk("spurious_acks", 64'({if_ack, mem_ack}), 64'd0);
      chk("spurious_bus_req", 64'(bus_req), 64'd0);
      tick();
      chk("spurious_state", 64'(bus_req), 64'd0);

      // ack in the last allowed cycle, then a real timeout
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
      serve(TO - 1);
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h304;
      serve(TO);

      // asynchronous reset during an IF transaction
      if_req = 1'b1; if_addr = 32'h500;
      tick();
      chk("mid_bus_req", 64'(bus_req), 64'd1);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_bus_req", 64'(bus_req), 64'd0);
      chk("mid_rst_if_ack", 64'(if_ack), 64'd0);
      chk("mid_rst_bus_err", 64'(bus_err), 64'd0);
      model_reset();
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600;
      @(negedge clk);
      rstn = 1'b1;
      serve(1);
      serve(0);

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         if (!if_req && $urandom_range(0, 1) == 1) begin
            if_req = 1'b1;
            if_addr = $urandom;
         end
         if (!mem_req && $urandom_range(0, 1) == 1) begin
            mem_req = 1'b1;
            mem_we = 1'($urandom_range(0, 1));
            mem_be = 4'($urandom_range(0, 15));
            mem_addr = $urandom;
            mem_wdata = $urandom;
         end
         if (!if_req && !mem_req) begin
            if_req = 1'b1;
            if_addr = $urandom;
         end
         if ($urandom_range(0, 3) == 0) begin
            bus_ack = 1'b1;
            bus_rdata = $urandom;
         end
         serve($urandom_range(0, TO));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
